// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Generic pipeline-stage register with a valid/ready handshake and a
// two-entry skid buffer. The stage payload fields are packed into one
// DATA_W-wide bus. in_ready comes straight from a flop, so a stall at the
// output never ripples combinationally back into the previous stage. A
// flush squashes every buffered entry.
//
// Parameters
//   DATA_W         width of the packed stage payload
//   ZERO_ON_FLUSH  1: flush also clears the payload regs, 0: valid bits only
//
// Ports
//   CLK        in   1       clock, rising edge
//   nRST       in   1       asynchronous reset, active-low
//   flush      in   1       synchronous squash of all held entries
//   in_valid   in   1       upstream stage has a payload
//   in_ready   out  1       stage can accept (registered)
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       main entry valid
//   out_ready  in   1       downstream accepts
//   out_data   out  DATA_W  main entry payload (always the oldest entry)
//   occupancy  out  2       number of entries held: 0, 1 or 2
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int DATA_W        = 128,
    parameter bit ZERO_ON_FLUSH = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // The state encoding doubles as the valid bits: bit 0 is main_v and
    // bit 1 is skid_v, so the handshake outputs are pure flop outputs.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              main_v;
    logic              skid_v;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;
    logic [DATA_W-1:0] main_d_nxt;
    logic [DATA_W-1:0] skid_d_nxt;
    logic              acc;
    logic              fire;

    assign main_v    = state[0];
    assign skid_v    = state[1];

    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

    assign acc  = in_valid & in_ready;
    assign fire = out_valid & out_ready;

    // State and payload registers. Reset clears everything so that the
    // outputs show an empty, zeroed stage as soon as nRST falls.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= EMPTY;
            main_d <= '0;
            skid_d <= '0;
        end else begin
            state  <= state_nxt;
            main_d <= main_d_nxt;
            skid_d <= skid_d_nxt;
        end
    end

    // Next-state and payload steering. Flush wins over everything; a
    // payload offered in the flush cycle is dropped, while a downstream
    // fire in that cycle has already been consumed by the next stage.
    // When the skid entry drains into main, the skid payload is left as
    // is because skid_v already marks it stale.
    always_comb begin
        state_nxt  = state;
        main_d_nxt = main_d;
        skid_d_nxt = skid_d;

        if (flush) begin
            state_nxt = EMPTY;
            if (ZERO_ON_FLUSH) begin
                main_d_nxt = '0;
                skid_d_nxt = '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nxt  = ONE;
                        main_d_nxt = in_data;
                    end
                end
                ONE: begin
                    if (acc && fire) begin
                        main_d_nxt = in_data;
                    end else if (acc) begin
                        state_nxt  = FULL;
                        skid_d_nxt = in_data;
                    end else if (fire) begin
                        state_nxt  = EMPTY;
                    end
                end
                FULL: begin
                    if (fire) begin
                        state_nxt  = ONE;
                        main_d_nxt = skid_d;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Bench for pipe_stage_skid. Two instances share every input: dutZ clears
// its payload on flush, dutK keeps it. A table of vectors covers streaming
// and backpressure, hand-written sequences cover flush and reset while
// full, and a random phase exercises valid/ready/flush. Each instance has
// its own scoreboard queue: payloads are pushed when accepted and popped
// and compared when the instance delivers them.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int W = 128;

    typedef struct {
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         fl;
        logic         eov;
        logic [W-1:0] eod;
        logic [1:0]   eocc;
        logic         eir;
    } vec_t;

    logic         CLK;
    logic         nRST;
    logic         flush;
    logic         inValid;
    logic [W-1:0] inData;
    logic         outReady;

    logic         inReadyZ;
    logic         outValidZ;
    logic [W-1:0] outDataZ;
    logic [1:0]   occZ;
    logic         inReadyK;
    logic         outValidK;
    logic [W-1:0] outDataK;
    logic [1:0]   occK;

    logic [W-1:0] qZ[$];
    logic [W-1:0] qK[$];
    vec_t         vecs[14];

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(.DATA_W(W), .ZERO_ON_FLUSH(1'b1)) dutZ (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReadyZ),
        .in_data   (inData),
        .out_valid (outValidZ),
        .out_ready (outReady),
        .out_data  (outDataZ),
        .occupancy (occZ)
    );

    pipe_stage_skid #(.DATA_W(W), .ZERO_ON_FLUSH(1'b0)) dutK (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReadyK),
        .in_data   (inData),
        .out_valid (outValidK),
        .out_ready (outReady),
        .out_data  (outDataK),
        .occupancy (occK)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mkVec(logic iv, logic [W-1:0] id, logic ordy, logic fl,
                                   logic eov, logic [W-1:0] eod, logic [1:0] eocc, logic eir);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
        v.eov = eov; v.eod = eod; v.eocc = eocc; v.eir = eir;
        return v;
    endfunction

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Same expectations on both instances.
    task automatic checkAll(input string name, input logic eov, input logic [W-1:0] eod,
                            input logic [1:0] eocc, input logic eir);
        checkOutput({name, " Z out_valid"}, W'(outValidZ), W'(eov));
        checkOutput({name, " Z out_data"},  outDataZ,      eod);
        checkOutput({name, " Z occupancy"}, W'(occZ),      W'(eocc));
        checkOutput({name, " Z in_ready"},  W'(inReadyZ),  W'(eir));
        checkOutput({name, " K out_valid"}, W'(outValidK), W'(eov));
        checkOutput({name, " K out_data"},  outDataK,      eod);
        checkOutput({name, " K occupancy"}, W'(occK),      W'(eocc));
        checkOutput({name, " K in_ready"},  W'(inReadyK),  W'(eir));
    endtask

    // Drive one cycle of inputs (called just after a rising edge), update
    // the scoreboards at the falling edge, and return just after the next
    // rising edge so outputs can be checked.
    task automatic applyStimulus(input logic iv, input logic [W-1:0] id,
                                 input logic ordy, input logic fl);
        inValid  = iv;
        inData   = id;
        outReady = ordy;
        flush    = fl;
        @(negedge CLK);
        if (outValidZ && outReady) begin
            if (qZ.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL sbZ: delivered %h, expected nothing", outDataZ);
            end else begin
                checkOutput("sbZ", outDataZ, qZ.pop_front());
            end
        end
        if (outValidK && outReady) begin
            if (qK.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL sbK: delivered %h, expected nothing", outDataK);
            end else begin
                checkOutput("sbK", outDataK, qK.pop_front());
            end
        end
        if (flush) begin
            qZ.delete();
            qK.delete();
        end else begin
            if (inValid && inReadyZ) qZ.push_back(inData);
            if (inValid && inReadyK) qK.push_back(inData);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic doReset();
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b0;
        flush    = 1'b0;
        nRST     = 1'b0;
        qZ.delete();
        qK.delete();
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [W-1:0] rdata;
        logic         riv;
        logic         rordy;
        logic         rfl;

        // Streaming 1..8 with out_ready high, then drain.
        for (int k = 1; k <= 8; k++)
            vecs[k-1] = mkVec(1'b1, W'(k), 1'b1, 1'b0, 1'b1, W'(k), 2'd1, 1'b1);
        vecs[8]  = mkVec(1'b0, '0,      1'b1, 1'b0, 1'b0, W'(8),   2'd0, 1'b1);
        // Backpressure: 0xA, 0xB held, 0xC refused, then drain in order.
        vecs[9]  = mkVec(1'b1, W'('hA), 1'b0, 1'b0, 1'b1, W'('hA), 2'd1, 1'b1);
        vecs[10] = mkVec(1'b1, W'('hB), 1'b0, 1'b0, 1'b1, W'('hA), 2'd2, 1'b0);
        vecs[11] = mkVec(1'b1, W'('hC), 1'b0, 1'b0, 1'b1, W'('hA), 2'd2, 1'b0);
        vecs[12] = mkVec(1'b0, '0,      1'b1, 1'b0, 1'b1, W'('hB), 2'd1, 1'b1);
        vecs[13] = mkVec(1'b0, '0,      1'b1, 1'b0, 1'b0, W'('hB), 2'd0, 1'b1);

        nRST     = 1'b1;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b0;
        flush    = 1'b0;
        #1;
        nRST = 1'b0;
        #2;
        checkAll("reset", 1'b0, '0, 2'd0, 1'b1);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        $display("[TB] vector table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl);
            checkAll($sformatf("vec%0d", i), vecs[i].eov, vecs[i].eod, vecs[i].eocc, vecs[i].eir);
        end

        $display("[TB] flush while full");
        applyStimulus(1'b1, W'('hA), 1'b0, 1'b0);
        applyStimulus(1'b1, W'('hB), 1'b0, 1'b0);
        checkAll("preFlush", 1'b1, W'('hA), 2'd2, 1'b0);
        applyStimulus(1'b1, W'('hC), 1'b0, 1'b1);
        checkOutput("flush Z out_valid", W'(outValidZ), '0);
        checkOutput("flush Z out_data",  outDataZ,      '0);
        checkOutput("flush Z in_ready",  W'(inReadyZ),  W'(1));
        checkOutput("flush Z occupancy", W'(occZ),      '0);
        checkOutput("flush K out_valid", W'(outValidK), '0);
        checkOutput("flush K out_data",  outDataK,      W'('hA));
        checkOutput("flush K in_ready",  W'(inReadyK),  W'(1));
        checkOutput("flush K occupancy", W'(occK),      '0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("postFlush Z out_valid", W'(outValidZ), '0);
        checkOutput("postFlush K out_valid", W'(outValidK), '0);

        $display("[TB] reset while full");
        applyStimulus(1'b1, W'('hA), 1'b0, 1'b0);
        applyStimulus(1'b1, W'('hB), 1'b0, 1'b0);
        checkAll("preReset", 1'b1, W'('hA), 2'd2, 1'b0);
        #2;
        nRST = 1'b0;
        #1;
        checkAll("rstFull", 1'b0, '0, 2'd0, 1'b1);
        inValid  = 1'b0;
        outReady = 1'b0;
        qZ.delete();
        qK.delete();
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        checkAll("afterRst", 1'b0, '0, 2'd0, 1'b1);

        $display("[TB] random valid/ready/flush");
        for (int n = 0; n < 10000; n++) begin
            riv   = 1'($urandom_range(0, 1));
            rordy = ($urandom_range(0, 9) < 6);
            rfl   = ($urandom_range(0, 49) == 0);
            rdata = {W'(n) << 32} | W'($urandom);
            applyStimulus(riv, rdata, rordy, rfl);
            checkOutput("rand Z in_ready", W'(inReadyZ), W'(occZ < 2'd2));
            checkOutput("rand K in_ready", W'(inReadyK), W'(occK < 2'd2));
        end
        for (int n = 0; n < 4; n++)
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("drain Z leftover", W'(qZ.size()), '0);
        checkOutput("drain K leftover", W'(qK.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
